// File: rtl/key_event_queue.sv
// key_event_queue
// Converts decoded PS/2 make/break notifications into 19-bit event records
// {make, shift, code[8:0], ascii[7:0]} and buffers them in a
// first-word-fall-through FIFO that a consumer drains with valid/ready.
// Left/right shift codes only contribute shift state; they are never queued.
// Optional build macro: KEY_EVENT_REPEAT_FILTER_EN -- suppresses typematic
// repeats using a shadow bitmap of keys already reported as pressed.
//
// Pop handshake: ev_valid is high whenever the FIFO holds at least one entry
// and the head fields (ev_code/ev_make/ev_shift/ev_ascii) are stable until
// accepted. An entry is consumed on a clock edge where ev_valid && ev_ready;
// ev_ready while ev_valid is low has no effect. ev_valid does not depend on
// ev_ready.
module key_event_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           key_valid,
  input  logic [8:0]     last_change,
  input  logic [511:0]   key_down,
  input  logic           ev_ready,
  input  logic           ovf_clr,
  output logic           ev_valid,
  output logic [8:0]     ev_code,
  output logic           ev_make,
  output logic           ev_shift,
  output logic [7:0]     ev_ascii,
  output logic [AW:0]    count,
  output logic           overflow
);

  localparam logic [8:0]  LSHIFT_CODE = 9'h012;
  localparam logic [8:0]  RSHIFT_CODE = 9'h059;
  localparam logic [AW:0] FULL_COUNT  = (AW+1)'(DEPTH);
  localparam int          EW          = 19;

  // Set-2 scan code to ASCII. Letters follow shift, digits and the few
  // control characters ignore it; extended codes are never mapped.
  function automatic logic [7:0] ascii_of(input logic [8:0] code,
                                          input logic       shift);
    logic [7:0] lower;
    logic [7:0] fixed;
    logic [7:0] result;
    lower = 8'h00;
    fixed = 8'h00;
    if (!code[8]) begin
      case (code[7:0])
        8'h1C: lower = 8'h61; // a
        8'h32: lower = 8'h62; // b
        8'h21: lower = 8'h63; // c
        8'h23: lower = 8'h64; // d
        8'h24: lower = 8'h65; // e
        8'h2B: lower = 8'h66; // f
        8'h34: lower = 8'h67; // g
        8'h33: lower = 8'h68; // h
        8'h43: lower = 8'h69; // i
        8'h3B: lower = 8'h6A; // j
        8'h42: lower = 8'h6B; // k
        8'h4B: lower = 8'h6C; // l
        8'h3A: lower = 8'h6D; // m
        8'h31: lower = 8'h6E; // n
        8'h44: lower = 8'h6F; // o
        8'h4D: lower = 8'h70; // p
        8'h15: lower = 8'h71; // q
        8'h2D: lower = 8'h72; // r
        8'h1B: lower = 8'h73; // s
        8'h2C: lower = 8'h74; // t
        8'h3C: lower = 8'h75; // u
        8'h2A: lower = 8'h76; // v
        8'h1D: lower = 8'h77; // w
        8'h22: lower = 8'h78; // x
        8'h35: lower = 8'h79; // y
        8'h1A: lower = 8'h7A; // z
        8'h45: fixed = 8'h30; // 0
        8'h16: fixed = 8'h31; // 1
        8'h1E: fixed = 8'h32; // 2
        8'h26: fixed = 8'h33; // 3
        8'h25: fixed = 8'h34; // 4
        8'h2E: fixed = 8'h35; // 5
        8'h36: fixed = 8'h36; // 6
        8'h3D: fixed = 8'h37; // 7
        8'h3E: fixed = 8'h38; // 8
        8'h46: fixed = 8'h39; // 9
        8'h29: fixed = 8'h20; // space
        8'h5A: fixed = 8'h0D; // enter
        8'h66: fixed = 8'h08; // backspace
        default: ;
      endcase
    end
    if (lower != 8'h00) begin
      result = shift ? (lower - 8'h20) : lower;
    end else begin
      result = fixed;
    end
    return result;
  endfunction

  // ---------------------------------------------------------------------
  // Capture of the decoder notification
  // ---------------------------------------------------------------------
  logic          is_modifier;
  logic          cap_make;
  logic          cap_shift;
  logic [7:0]    cap_ascii;
  logic [EW-1:0] cap_entry;
  logic          repeat_hit;

  assign is_modifier = (last_change == LSHIFT_CODE) || (last_change == RSHIFT_CODE);
  assign cap_make    = key_down[last_change];
  assign cap_shift   = key_down[LSHIFT_CODE] | key_down[RSHIFT_CODE];
  assign cap_ascii   = ascii_of(last_change, cap_shift);
  assign cap_entry   = {cap_make, cap_shift, last_change, cap_ascii};

  // ---------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          push_req;
  logic          do_push;
  logic          do_pop;
  logic          ovf_set;

  assign ev_valid = (count != '0);
  assign full     = (count == FULL_COUNT);
  assign do_pop   = ev_valid && ev_ready;
  assign push_req = key_valid && !is_modifier && !repeat_hit;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push  = push_req && (!full || do_pop);
  assign ovf_set  = push_req && full && !do_pop;

`ifdef KEY_EVENT_REPEAT_FILTER_EN
  logic [511:0] shadow;

  assign repeat_hit = key_valid && !is_modifier && cap_make && shadow[last_change];

  // Shadow of keys reported as down: set by an enqueued make, cleared by any break.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (key_valid && !is_modifier) begin
      if (!cap_make) begin
        shadow[last_change] <= 1'b0;
      end else if (do_push) begin
        shadow[last_change] <= 1'b1;
      end
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; stale data is harmless because the outputs are gated by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= cap_entry;
    end
  end

  // Sticky overflow: a new drop in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Head presentation, forced to zero while empty
  // ---------------------------------------------------------------------
  logic [EW-1:0] head;

  assign head     = ev_valid ? mem[rd_ptr] : '0;
  assign ev_make  = head[18];
  assign ev_shift = head[17];
  assign ev_code  = head[16:8];
  assign ev_ascii = head[7:0];

endmodule

// File: tb/tb_key_event_queue.sv
// tb_key_event_queue
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a queue-based reference of the key event FIFO. Build with
// +define+KEY_EVENT_REPEAT_FILTER_EN to exercise the repeat filter.
module tb_key_event_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int W     = 19;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  initial forever #5 clk = ~clk;

  logic           key_valid;
  logic [8:0]     last_change;
  logic [511:0]   key_down;
  logic           ev_ready;
  logic           ovf_clr;
  logic           ev_valid;
  logic [8:0]     ev_code;
  logic           ev_make;
  logic           ev_shift;
  logic [7:0]     ev_ascii;
  logic [AW:0]    count;
  logic           overflow;

  key_event_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .last_change (last_change),
    .key_down    (key_down),
    .ev_ready    (ev_ready),
    .ovf_clr     (ovf_clr),
    .ev_valid    (ev_valid),
    .ev_code     (ev_code),
    .ev_make     (ev_make),
    .ev_shift    (ev_shift),
    .ev_ascii    (ev_ascii),
    .count       (count),
    .overflow    (overflow)
  );

  // ---------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------
  // Alphabetical order: index i is letter 'a'+i.
  logic [7:0] letter_codes [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  // Index i is digit i.
  logic [7:0] digit_codes [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [8:0] code_pool [16] = '{
    9'h01C, 9'h032, 9'h015, 9'h01A, 9'h045, 9'h046, 9'h029, 9'h05A,
    9'h066, 9'h012, 9'h059, 9'h175, 9'h11C, 9'h076, 9'h00E, 9'h04D};

  logic [W-1:0] exp_q[$];
  logic         m_ovf;
  logic [511:0] m_shadow;
  int           compared;
  int           mismatched;

  function automatic logic [7:0] ref_ascii(input logic [8:0] code, input logic sh);
    if (code[8]) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == code[7:0]) return sh ? 8'(65 + i) : 8'(97 + i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == code[7:0]) return 8'(48 + i);
    if (code[7:0] == 8'h29) return 8'h20;
    if (code[7:0] == 8'h5A) return 8'h0D;
    if (code[7:0] == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_ovf    = 1'b0;
    m_shadow = '0;
  endtask

  // Applies the inputs present at this clock edge to the reference.
  task automatic model_step();
    logic pop, mk, sh, want, new_ovf;
    pop     = (exp_q.size() != 0) && ev_ready;
    new_ovf = 1'b0;
    want    = 1'b0;
    mk      = key_down[last_change];
    sh      = key_down[9'h012] | key_down[9'h059];
    if (key_valid && last_change != 9'h012 && last_change != 9'h059) begin
      want = 1'b1;
`ifdef KEY_EVENT_REPEAT_FILTER_EN
      if (mk && m_shadow[last_change]) want = 1'b0;
      if (!mk) m_shadow[last_change] = 1'b0;
`endif
    end
    if (pop) void'(exp_q.pop_front());
    if (want) begin
      if (exp_q.size() < DEPTH) begin
        exp_q.push_back({mk, sh, last_change, ref_ascii(last_change, sh)});
`ifdef KEY_EVENT_REPEAT_FILTER_EN
        if (mk) m_shadow[last_change] = 1'b1;
`endif
      end else begin
        new_ovf = 1'b1;
      end
    end
    if (new_ovf) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] exp_head;
    exp_head = (exp_q.size() != 0) ? exp_q[0] : '0;
    chk("ev_valid", 32'(ev_valid), 32'(exp_q.size() != 0));
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("head", 32'({ev_make, ev_shift, ev_code, ev_ascii}), 32'(exp_head));
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic key_event(input logic [8:0] code, input logic mk);
    key_down[code] = mk;
    last_change    = code;
    key_valid      = 1'b1;
    cycle();
    key_valid      = 1'b0;
  endtask

  task automatic drain();
    ev_ready = 1'b1;
    for (int i = 0; i < 2 * DEPTH + 4; i++) begin
      if (exp_q.size() == 0) break;
      cycle();
    end
    ev_ready = 1'b0;
    cycle();
    chk("drain_empty", 32'(count), 32'd0);
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    compared    = 0;
    mismatched  = 0;
    rst_n       = 1'b0;
    key_valid   = 1'b0;
    last_change = '0;
    key_down    = '0;
    ev_ready    = 1'b0;
    ovf_clr     = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_valid", 32'(ev_valid), 32'd0);
    #3 rst_n = 1'b1;
    cycle();

    // Lower-case press
    key_event(9'h01C, 1'b1);
    chk("t1_valid", 32'(ev_valid), 32'd1);
    chk("t1_code", 32'(ev_code), 32'h01C);
    chk("t1_make", 32'(ev_make), 32'd1);
    chk("t1_shift", 32'(ev_shift), 32'd0);
    chk("t1_ascii", 32'(ev_ascii), 32'h61);
    chk("t1_count", 32'(count), 32'd1);
    key_event(9'h01C, 1'b0);
    drain();

    // Shift held silently, then press/release
    key_down[9'h012] = 1'b1;
    key_event(9'h01C, 1'b1);
    chk("t2_shift", 32'(ev_shift), 32'd1);
    chk("t2_ascii", 32'(ev_ascii), 32'h41);
    key_event(9'h01C, 1'b0);
    ev_ready = 1'b1;
    cycle();
    ev_ready = 1'b0;
    chk("t2_brk_make", 32'(ev_make), 32'd0);
    chk("t2_brk_ascii", 32'(ev_ascii), 32'h41);
    key_down[9'h012] = 1'b0;
    drain();

    // Extended code, then shift-only events
    key_event(9'h175, 1'b1);
    chk("t3_code", 32'(ev_code), 32'h175);
    chk("t3_ascii", 32'(ev_ascii), 32'h00);
    key_event(9'h175, 1'b0);
    drain();
    key_event(9'h012, 1'b1);
    key_event(9'h012, 1'b0);
    key_event(9'h059, 1'b1);
    key_event(9'h059, 1'b0);
    chk("t3_mod_count", 32'(count), 32'd0);

    // Overflow with nine presses, then clear
    begin
      logic [8:0] nine [9] = '{9'h015, 9'h01D, 9'h024, 9'h02D, 9'h02C,
                               9'h035, 9'h03C, 9'h043, 9'h044};
      for (int i = 0; i < 9; i++) key_event(nine[i], 1'b1);
    end
    chk("t4_count", 32'(count), 32'd8);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_head", 32'(ev_code), 32'h015);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 32'd0);

    // Push and pop together while full
    ev_ready = 1'b1;
    key_event(9'h04D, 1'b1);
    ev_ready = 1'b0;
    chk("t5_count", 32'(count), 32'd8);
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_head", 32'(ev_code), 32'h01D);
    drain();

    // Typematic repeats of space
    key_event(9'h029, 1'b1);
    key_event(9'h029, 1'b1);
    key_event(9'h029, 1'b1);
    key_event(9'h029, 1'b0);
`ifdef KEY_EVENT_REPEAT_FILTER_EN
    chk("t6_count", 32'(count), 32'd2);
`else
    chk("t6_count", 32'(count), 32'd4);
`endif
    chk("t6_ascii", 32'(ev_ascii), 32'h20);
    drain();

    // Randomized traffic: starved consumer first, then an eager one
    for (int n = 0; n < 600; n++) begin
      logic [8:0] code;
      key_valid = ($urandom_range(0, 2) == 0);
      if (key_valid) begin
        code           = code_pool[$urandom_range(0, 15)];
        key_down[code] = 1'($urandom_range(0, 1));
        last_change    = code;
      end
      ev_ready = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      cycle();
    end
    key_valid = 1'b0;
    ovf_clr   = 1'b0;

    // Asynchronous reset in the middle of traffic
    ev_ready = 1'b0;
    key_event(9'h016, 1'b1);
    key_event(9'h01E, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_valid", 32'(ev_valid), 32'd0);
    chk("rst_mid_head", 32'({ev_make, ev_shift, ev_code, ev_ascii}), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    cycle();
    key_event(9'h026, 1'b1);
    chk("post_rst_ascii", 32'(ev_ascii), 32'h33);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
